dcache_mem_arb: RTL and testbench
=================================

DCACHE_MEM_ARB -- requirements
Module: dcache_mem_arb

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of memory words.
REQ-002 SHALL have parameter DATA_W, default 32, memory word width.
REQ-003 SHALL have derived parameter AW = $clog2(DEPTH), address width (8 at default).
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports rN_valid_i, input, 1, request valid from requester N (N = 0, 1).
REQ-007 SHALL have ports rN_ready_o, output, 1, request accepted this cycle.
REQ-008 SHALL have ports rN_we_i, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have ports rN_addr_i, input, AW, word address.
REQ-010 SHALL have ports rN_wdata_i, input, DATA_W, write data.
REQ-011 SHALL have ports rN_lock_i, input, 1, hold grant after this transfer.
REQ-012 SHALL have port rvalid_o, output, 2, bit N = read response for requester N.
REQ-013 SHALL have port rdata_o, output, DATA_W, read response data.
REQ-014 SHALL have ports mem_ceb_o / mem_ren_o / mem_wen_o, output, 1 each, memory chip enable, read enable and write enable (all active-high).
REQ-015 SHALL have ports mem_addr_o (AW) and mem_wdata_o (DATA_W), outputs, memory address and write data.
REQ-016 SHALL have port mem_rdata_i, input, DATA_W, memory read data, registered, valid one cycle after the read strobe.

Function
REQ-017 SHALL transfer a request when rN_valid_i and rN_ready_o are both 1; at most one rN_ready_o SHALL be 1 per cycle.
REQ-018 SHALL drive rN_ready_o combinationally from the valid inputs and arbiter state, with no wait states: any eligible valid SHALL be granted in the same cycle.
REQ-019 SHALL grant the only valid requester when exactly one requester is valid and eligible.
REQ-020 SHALL grant the requester other than last_grant when both are valid and eligible, and SHALL update last_grant to the winner on each transfer.
REQ-021 SHALL set a lock, owned by the winner, when the winning transfer has rN_lock_i = 1.
REQ-022 SHALL, while the lock is held, treat only the owner as eligible; the other requester SHALL see ready = 0 even if the owner is idle.
REQ-023 SHALL clear the lock on the owner's first transfer with rN_lock_i = 0; that transfer itself SHALL still be granted to the owner.
REQ-024 SHALL, in a grant cycle, drive mem_ceb_o = 1, mem_wen_o = winner we, mem_ren_o = not winner we, and mem_addr_o / mem_wdata_o from the winner.
REQ-025 SHALL, in a no-grant cycle, drive mem_ceb_o, mem_ren_o and mem_wen_o to 0, and mem_addr_o and mem_wdata_o to 0.
REQ-026 SHALL, for an accepted read, assert rvalid_o[N] for exactly one cycle, one cycle after acceptance, with rdata_o = mem_rdata_i in that cycle.
REQ-027 SHALL produce no response for an accepted write.
REQ-028 SHALL drive rdata_o to 0 when rvalid_o is 0.
REQ-029 SHALL sustain 1 access per cycle; back-to-back reads SHALL produce back-to-back responses in acceptance order.
REQ-030 SHALL, for a read and a write to the same address in consecutive cycles, return the old data for read-then-write and the new data for write-then-read.
REQ-031 SHALL have at most one rvalid_o bit set at a time.

Reset
REQ-032 SHALL, while rst_i = 1 at a clock edge, clear last_grant to 1, clear the lock and clear the response pipeline.
REQ-033 SHALL hold rN_ready_o = 0, rvalid_o = 0, rdata_o = 0 and all mem_* outputs = 0 while rst_i = 1, regardless of inputs.
REQ-034 SHALL, on reset asserted mid-operation, discard any pending read response (no rvalid_o after reset deasserts) and release any held lock.
REQ-035 SHALL give requester 0 the first tie after reset.

Verification
REQ-036 SHALL cover this case: reset, then both valid for 4 cycles, all reads to addresses 0x10 and 0x20 -> grants alternate r0, r1, r0, r1; rvalid_o = 01, 10, 01, 10 starting one cycle after the first grant.
REQ-037 SHALL cover this case: r0 writes 0xDEADBEEF to 0x05, then next cycle reads 0x05 -> mem_wen_o = 1 then mem_ren_o = 1; rvalid_o = 01 with rdata_o = 0xDEADBEEF.
REQ-038 SHALL cover this case: r1 lock = 1 for 3 transfers then lock = 0, with r0 continuously valid -> r0_ready_o = 0 for those 4 cycles; r0 is granted in the cycle after r1's unlocking transfer.
REQ-039 SHALL cover this case: r1 holds the lock then deasserts valid for 2 cycles, r0 valid -> no grant and mem_ceb_o = 0 for both cycles.
REQ-040 SHALL cover this case: r0 read accepted at cycle T, rst_i = 1 at T+1 -> rvalid_o stays 0 through T+1 and T+2; after reset the first tie goes to r0.
REQ-041 SHALL cover this case: no valid requests -> all mem_* outputs = 0, ready = 0, rvalid_o = 0.

Source files
------------

// File: rtl/dcache_mem_arb.sv
// dcache_mem_arb
//   Two-requester arbiter in front of a single-port synchronous SRAM.
//   Requests are granted in the same cycle they are presented (no wait
//   states). Ties alternate against the last winner. A winner may lock
//   the port across several transfers. Read data comes back one cycle
//   after acceptance, tagged by requester.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   rN_valid_i / rN_ready_o      request handshake, requester N = 0, 1
//   rN_we_i, rN_addr_i,
//   rN_wdata_i, rN_lock_i        request payload; lock keeps the grant
//   rvalid_o[1:0], rdata_o       read response (bit N = requester N)
//   mem_ceb_o, mem_ren_o,
//   mem_wen_o, mem_addr_o,
//   mem_wdata_o                  SRAM strobes, address and write data
//   mem_rdata_i                  SRAM read data, one cycle after strobe
module dcache_mem_arb #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              r0_valid_i,
    output logic              r0_ready_o,
    input  logic              r0_we_i,
    input  logic [AW-1:0]     r0_addr_i,
    input  logic [DATA_W-1:0] r0_wdata_i,
    input  logic              r0_lock_i,
    input  logic              r1_valid_i,
    output logic              r1_ready_o,
    input  logic              r1_we_i,
    input  logic [AW-1:0]     r1_addr_i,
    input  logic [DATA_W-1:0] r1_wdata_i,
    input  logic              r1_lock_i,
    output logic [1:0]        rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              mem_ceb_o,
    output logic              mem_ren_o,
    output logic              mem_wen_o,
    output logic [AW-1:0]     mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef struct packed {
        logic              valid;
        logic              we;
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] wdata;
        logic              lock;
    } req_t;

    req_t [1:0] req;
    req_t       win_req;

    logic       last_grant_q;   // index of the previous winner
    logic       lock_q;
    logic       lock_owner_q;
    logic [1:0] rvld_q;         // one-hot tag of the read accepted last cycle

    logic [1:0] cand;
    logic [1:0] gnt;
    logic       win;
    logic       xfer;

    assign req[0].valid = r0_valid_i;
    assign req[0].we    = r0_we_i;
    assign req[0].addr  = r0_addr_i;
    assign req[0].wdata = r0_wdata_i;
    assign req[0].lock  = r0_lock_i;
    assign req[1].valid = r1_valid_i;
    assign req[1].we    = r1_we_i;
    assign req[1].addr  = r1_addr_i;
    assign req[1].wdata = r1_wdata_i;
    assign req[1].lock  = r1_lock_i;

    // Eligibility: while locked only the owner may compete, even when idle.
    // Reset masks everything so no strobe escapes during the reset cycle.
    always_comb begin
        cand = 2'b00;
        for (int i = 0; i < 2; i++) begin
            cand[i] = req[i].valid && !rst_i &&
                      (!lock_q || (lock_owner_q == 1'(i)));
        end
        gnt = 2'b00;
        unique case (cand)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    assign win     = gnt[1];
    assign xfer    = |gnt;
    assign win_req = req[win];

    assign r0_ready_o  = gnt[0];
    assign r1_ready_o  = gnt[1];
    assign mem_ceb_o   = xfer;
    assign mem_wen_o   = xfer &&  win_req.we;
    assign mem_ren_o   = xfer && !win_req.we;
    assign mem_addr_o  = xfer ? win_req.addr  : '0;
    assign mem_wdata_o = xfer ? win_req.wdata : '0;

    // last_grant resets to 1 so the first tie goes to requester 0.
    // While locked only the owner transfers, so copying the winner's lock
    // bit both sets and releases the lock.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_q <= 1'b1;
            lock_q       <= 1'b0;
            lock_owner_q <= 1'b0;
            rvld_q       <= 2'b00;
        end else begin
            if (xfer) begin
                last_grant_q <= win;
                lock_q       <= win_req.lock;
                lock_owner_q <= win;
            end
            rvld_q <= (xfer && !win_req.we) ? gnt : 2'b00;
        end
    end

    // Gating with rst_i drops a response that would land in the first
    // reset cycle, before the register itself has been cleared.
    assign rvalid_o = rst_i ? 2'b00 : rvld_q;
    assign rdata_o  = (|rvalid_o) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_dcache_mem_arb.sv
module tb_dcache_mem_arb;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        r0_valid_i, r0_we_i, r0_lock_i, r0_ready_o;
    logic        r1_valid_i, r1_we_i, r1_lock_i, r1_ready_o;
    logic [7:0]  r0_addr_i, r1_addr_i, mem_addr_o;
    logic [31:0] r0_wdata_i, r1_wdata_i, mem_wdata_o, mem_rdata_i, rdata_o;
    logic [1:0]  rvalid_o;
    logic        mem_ceb_o, mem_ren_o, mem_wen_o;

    dcache_mem_arb #(.DEPTH(256), .DATA_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .r0_valid_i(r0_valid_i), .r0_ready_o(r0_ready_o), .r0_we_i(r0_we_i),
        .r0_addr_i(r0_addr_i), .r0_wdata_i(r0_wdata_i), .r0_lock_i(r0_lock_i),
        .r1_valid_i(r1_valid_i), .r1_ready_o(r1_ready_o), .r1_we_i(r1_we_i),
        .r1_addr_i(r1_addr_i), .r1_wdata_i(r1_wdata_i), .r1_lock_i(r1_lock_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .mem_ceb_o(mem_ceb_o), .mem_ren_o(mem_ren_o), .mem_wen_o(mem_wen_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // SRAM model: registered read, write on strobe.
    logic [31:0] mem [256];
    always @(posedge clk_i) begin
        if (mem_ceb_o && mem_wen_o) mem[mem_addr_o] <= mem_wdata_o;
        if (mem_ceb_o && mem_ren_o) mem_rdata_i <= mem[mem_addr_o];
    end

    typedef struct {
        logic [1:0]  rv;
        logic [31:0] d;
    } rsp_t;

    rsp_t        sb[$];          // expected response per cycle
    logic [31:0] shadow [256];   // expected memory contents
    int          checks = 0;
    int          passes = 0;
    int          fails  = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int n, input logic v, input logic we,
                       input logic [7:0] a, input logic [31:0] d, input logic l);
        if (n == 0) begin
            r0_valid_i = v; r0_we_i = we; r0_addr_i = a; r0_wdata_i = d; r0_lock_i = l;
        end else begin
            r1_valid_i = v; r1_we_i = we; r1_addr_i = a; r1_wdata_i = d; r1_lock_i = l;
        end
    endtask

    // One clock: check grant and memory strobes against the expected grant,
    // pop the expected response for this cycle, push next cycle's.
    task automatic cyc(input logic [1:0] er, input string tag);
        logic        g, we;
        logic [7:0]  a;
        logic [31:0] d;
        rsp_t        e, n;
        @(negedge clk_i);
        g  = |er;
        we = er[1] ? r1_we_i   : r0_we_i;
        a  = er[1] ? r1_addr_i : r0_addr_i;
        d  = er[1] ? r1_wdata_i : r0_wdata_i;
        chk({tag, ".ready"}, 32'({r1_ready_o, r0_ready_o}), 32'(er));
        chk({tag, ".ceb"},   32'(mem_ceb_o), 32'(g));
        chk({tag, ".wen"},   32'(mem_wen_o), 32'(g && we));
        chk({tag, ".ren"},   32'(mem_ren_o), 32'(g && !we));
        chk({tag, ".addr"},  32'(mem_addr_o), g ? 32'(a) : 32'h0);
        chk({tag, ".wdata"}, mem_wdata_o, g ? d : 32'h0);
        e.rv = 2'b00; e.d = 32'h0;
        if (sb.size() != 0) e = sb.pop_front();
        if (rst_i) begin e.rv = 2'b00; e.d = 32'h0; end
        chk({tag, ".rvalid"}, 32'(rvalid_o), 32'(e.rv));
        chk({tag, ".rdata"},  rdata_o, e.d);
        n.rv = 2'b00; n.d = 32'h0;
        if (g && !we && !rst_i) begin n.rv = er; n.d = shadow[a]; end
        if (g && we && !rst_i) shadow[a] = d;
        sb.push_back(n);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rsp_t z;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 32'hA5A5_0000 + 32'(i);
            shadow[i] = 32'hA5A5_0000 + 32'(i);
        end
        mem_rdata_i = 32'h0;
        z.rv = 2'b00; z.d = 32'h0;
        sb.push_back(z);
        rst_i = 1'b1;

        // Reset holds everything quiet even with both requesters valid.
        drv(0, 1, 0, 8'h10, 32'h0, 0);
        drv(1, 1, 1, 8'h20, 32'h1111, 1);
        cyc(2'b00, "rst0");
        cyc(2'b00, "rst1");

        // Alternating reads, first tie to r0.
        rst_i = 1'b0;
        drv(1, 1, 0, 8'h20, 32'h0, 0);
        cyc(2'b01, "alt0");
        cyc(2'b10, "alt1");
        cyc(2'b01, "alt2");
        cyc(2'b10, "alt3");
        drv(0, 0, 0, 8'h00, 32'h0, 0);
        drv(1, 0, 0, 8'h00, 32'h0, 0);
        cyc(2'b00, "idle0");

        // Write then read same address returns new data.
        drv(0, 1, 1, 8'h05, 32'hDEADBEEF, 0);
        cyc(2'b01, "wr05");
        drv(0, 1, 0, 8'h05, 32'h0, 0);
        cyc(2'b01, "rd05");
        drv(0, 0, 0, 8'h00, 32'h0, 0);
        // Read then write same address returns old data.
        drv(1, 1, 0, 8'h06, 32'h0, 0);
        cyc(2'b10, "rd06");
        drv(1, 1, 1, 8'h06, 32'h12345678, 0);
        cyc(2'b10, "wr06");
        drv(1, 0, 0, 8'h00, 32'h0, 0);
        cyc(2'b00, "idle1");

        // r1 locks for 3 transfers then unlocks; r0 waits throughout.
        drv(0, 1, 0, 8'h30, 32'h0, 0);
        cyc(2'b01, "pre");
        drv(1, 1, 0, 8'h40, 32'h0, 1);
        cyc(2'b10, "lk0");
        cyc(2'b10, "lk1");
        cyc(2'b10, "lk2");
        drv(1, 1, 0, 8'h06, 32'h0, 0);
        cyc(2'b10, "unlk");
        drv(1, 0, 0, 8'h00, 32'h0, 0);
        cyc(2'b01, "after_unlk");
        drv(0, 0, 0, 8'h00, 32'h0, 0);
        cyc(2'b00, "idle2");

        // Owner goes idle while holding the lock: no grant at all.
        drv(1, 1, 1, 8'h41, 32'hCAFEF00D, 1);
        cyc(2'b10, "lkwr");
        drv(1, 0, 0, 8'h00, 32'h0, 0);
        drv(0, 1, 0, 8'h30, 32'h0, 0);
        cyc(2'b00, "lkidle0");
        cyc(2'b00, "lkidle1");
        drv(1, 1, 0, 8'h41, 32'h0, 0);
        cyc(2'b10, "lkrd");
        drv(1, 0, 0, 8'h00, 32'h0, 0);
        cyc(2'b01, "lkrel");
        drv(0, 0, 0, 8'h00, 32'h0, 0);
        cyc(2'b00, "idle3");

        // Reset mid-operation drops the pending response.
        drv(0, 1, 0, 8'h10, 32'h0, 0);
        cyc(2'b01, "rdT");
        rst_i = 1'b1;
        drv(1, 1, 0, 8'h20, 32'h0, 0);
        cyc(2'b00, "rstT1");
        rst_i = 1'b0;
        drv(0, 0, 0, 8'h00, 32'h0, 0);
        drv(1, 0, 0, 8'h00, 32'h0, 0);
        cyc(2'b00, "rstT2");

        // Reset releases a held lock and restores r0 tie priority.
        drv(1, 1, 0, 8'h20, 32'h0, 1);
        cyc(2'b10, "lkacq");
        rst_i = 1'b1;
        cyc(2'b00, "rstlk");
        rst_i = 1'b0;
        drv(0, 1, 0, 8'h05, 32'h0, 0);
        drv(1, 1, 0, 8'h06, 32'h0, 0);
        cyc(2'b01, "tie_r0");
        cyc(2'b10, "tie_r1");
        drv(0, 0, 0, 8'h00, 32'h0, 0);
        drv(1, 0, 0, 8'h00, 32'h0, 0);
        cyc(2'b00, "idle4");
        cyc(2'b00, "idle5");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
